clk_ratio_meter: RTL and testbench

- Measures a divided clock (`sig_in`) against the system clock `clk_in`.
- Reports the period and high time in `clk_in` cycles, i.e. it recovers the division ratio.
- Companion/checker to the team's clock divider: on-chip self-test of divided clocks and debug readback of the effective `div`.
- Sits in the `clk_in` domain; `sig_in` may optionally be resynchronised.

---
 rtl/clk_ratio_meter.sv | 158 +++++++++++++++
 tb/tb_clk_ratio_meter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_ratio_meter.sv
// Measures the period and high time of a divided clock (sig_in) in clk_in cycles,
// recovering the division ratio and flagging lock and loss of signal.
module clk_ratio_meter #(
    parameter int          SYNC_STAGES = 0,
    parameter int          LOCK_COUNT  = 4,
    parameter logic [31:0] TIMEOUT     = 32'd1048576
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        enable,
    input  logic        sig_in,
    output logic [31:0] period,
    output logic [31:0] high_time,
    output logic        meas_valid,
    output logic        locked,
    output logic        timeout,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        TRACK = 2'b10
    } state_t;

    localparam int         PW       = SYNC_STAGES + 1;
    localparam logic [3:0] LOCK_MAX = 4'(LOCK_COUNT);

    logic          s;
    logic          s_d_q;
    logic [PW-1:0] primed_q, primed_d;
    logic          rise;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] hcnt_q, hcnt_d;
    logic [31:0] period_q, period_d;
    logic [31:0] high_q, high_d;
    logic [3:0]  match_q, match_d;
    logic        mv_q, mv_d;
    logic        locked_q, locked_d;
    logic        to_q, to_d;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = sig_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q, sync_d;

            always_comb sync_d = (sync_q << 1) | SYNC_STAGES'(sig_in);

            always_ff @(posedge clk_in) begin
                if (!reset) sync_q <= '0;
                else        sync_q <= sync_d;
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // A rise only counts once s_d holds a real sample, so a high level at reset release never arms.
    always_comb primed_d = (primed_q << 1) | PW'(1);
    assign rise = s & ~s_d_q & primed_q[PW-1];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hcnt_d   = hcnt_q;
        period_d = period_q;
        high_d   = high_q;
        match_d  = match_q;
        locked_d = locked_q;
        mv_d     = 1'b0;
        to_d     = 1'b0;
        if (!enable) begin
            state_d  = IDLE;
            cnt_d    = '0;
            hcnt_d   = '0;
            match_d  = '0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d  = '0;
                    hcnt_d = '0;
                    if (rise) begin
                        state_d = ARMED;
                        cnt_d   = 32'd1;
                        hcnt_d  = 32'd1;
                    end
                end
                ARMED, TRACK: begin
                    if (rise) begin
                        state_d  = TRACK;
                        period_d = cnt_q;
                        high_d   = hcnt_q;
                        mv_d     = 1'b1;
                        cnt_d    = 32'd1;
                        hcnt_d   = 32'd1;
                        if (state_q == ARMED)       match_d = 4'd1;
                        else if (cnt_q == period_q) match_d = (match_q >= LOCK_MAX) ? LOCK_MAX : match_q + 4'd1;
                        else                        match_d = 4'd1;
                        locked_d = (match_d == LOCK_MAX);
                    end else if (cnt_q == TIMEOUT) begin
                        state_d  = IDLE;
                        to_d     = 1'b1;
                        cnt_d    = '0;
                        hcnt_d   = '0;
                        period_d = '0;
                        high_d   = '0;
                        match_d  = '0;
                        locked_d = 1'b0;
                    end else begin
                        cnt_d  = cnt_q + 32'd1;
                        hcnt_d = hcnt_q + {31'b0, s};
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            s_d_q    <= 1'b0;
            primed_q <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            match_q  <= '0;
            mv_q     <= 1'b0;
            locked_q <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            s_d_q    <= s;
            primed_q <= primed_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            period_q <= period_d;
            high_q   <= high_d;
            match_q  <= match_d;
            mv_q     <= mv_d;
            locked_q <= locked_d;
            to_q     <= to_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = mv_q;
    assign locked     = locked_q;
    assign timeout    = to_q;
    assign state      = state_q;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Scoreboard bench for clk_ratio_meter: one instance with sig_in already synchronous and
// one with a two-flop synchroniser, both fed by the same bench-generated divided clock.
module tb_clk_ratio_meter;

    localparam int LOCK = 4;
    localparam int TMO  = 64;

    typedef struct {
        logic [31:0] per;
        logic [31:0] hi;
        logic        lk;
        int          cyc;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b0;
    logic        enable = 1'b0;
    logic        sig_in = 1'b0;

    logic [31:0] period0, high0, period1, high1;
    logic        mv0, mv1, lk0, lk1, to0, to1;
    logic [1:0]  st0, st1;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q0[$];
    exp_t q1[$];

    // Reference model of what a correct meter should report for the driven waveform
    logic lastV     = 1'b0;
    bit   mdlActive = 1'b0;
    bit   mdlFirst  = 1'b0;
    int   mdlMatch  = 0;
    int   lastLen   = 0;
    int   riseCyc   = 0;
    int   hiAcc     = 0;
    int   expTo     = 0;

    int   lastMv0 = 0, lastMv1 = 0, toCnt0 = 0, toCnt1 = 0;
    exp_t e0, e1;

    clk_ratio_meter #(.SYNC_STAGES(0), .LOCK_COUNT(LOCK), .TIMEOUT(32'd64)) u_dut0 (
        .clk_in(clk_in), .reset(reset), .enable(enable), .sig_in(sig_in),
        .period(period0), .high_time(high0), .meas_valid(mv0), .locked(lk0),
        .timeout(to0), .state(st0)
    );

    clk_ratio_meter #(.SYNC_STAGES(2), .LOCK_COUNT(LOCK), .TIMEOUT(32'd64)) u_dut1 (
        .clk_in(clk_in), .reset(reset), .enable(enable), .sig_in(sig_in),
        .period(period1), .high_time(high1), .meas_valid(mv1), .locked(lk1),
        .timeout(to1), .state(st1)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Drives one clk_in cycle of sig_in and predicts measurements/timeouts it causes
    task automatic driveCycle(input logic v);
        exp_t e;
        int   len;
        if (reset && enable && v && !lastV) begin
            if (mdlActive) begin
                len = cyc - riseCyc;
                if (mdlFirst)            mdlMatch = 1;
                else if (len == lastLen) mdlMatch = (mdlMatch + 1 > LOCK) ? LOCK : mdlMatch + 1;
                else                     mdlMatch = 1;
                mdlFirst = 1'b0;
                lastLen  = len;
                e.per = 32'(len);
                e.hi  = 32'(hiAcc);
                e.lk  = (mdlMatch == LOCK);
                e.cyc = cyc;
                q0.push_back(e);
                q1.push_back(e);
            end else begin
                mdlActive = 1'b1;
                mdlFirst  = 1'b1;
            end
            riseCyc = cyc;
            hiAcc   = 0;
        end else if (reset && mdlActive && (cyc - riseCyc == TMO)) begin
            mdlActive = 1'b0;
            expTo++;
        end
        if (mdlActive && v) hiAcc++;
        sig_in = v;
        lastV  = v;
        @(negedge clk_in);
    endtask

    task automatic applyStimulus(input int hi, input int lo, input int n);
        repeat (n) begin
            repeat (hi) driveCycle(1'b1);
            repeat (lo) driveCycle(1'b0);
        end
    endtask

    task automatic setEnable(input logic v);
        enable = v;
        if (!v) mdlActive = 1'b0;
    endtask

    task automatic checkBoth(input string tag, input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] exp);
        checkOutput({tag, "0"}, a0, exp);
        checkOutput({tag, "1"}, a1, exp);
    endtask

    task automatic checkAllZero(input string tag);
        checkBoth({tag, "Period"}, period0, period1, 0);
        checkBoth({tag, "High"}, high0, high1, 0);
        checkBoth({tag, "Mv"}, 32'(mv0), 32'(mv1), 0);
        checkBoth({tag, "Locked"}, 32'(lk0), 32'(lk1), 0);
        checkBoth({tag, "Timeout"}, 32'(to0), 32'(to1), 0);
        checkBoth({tag, "State"}, 32'(st0), 32'(st1), 0);
    endtask

    // Scoreboard pop for the unsynchronised instance; result appears 1 cycle after the drive
    always @(negedge clk_in) begin
        if (mv0 === 1'b1) begin
            if (q0.size() == 0) checkOutput("mvSpurious0", 1, 0);
            else begin
                e0 = q0.pop_front();
                checkOutput("period0", period0, e0.per);
                checkOutput("high0", high0, e0.hi);
                checkOutput("lockedMv0", 32'(lk0), 32'(e0.lk));
                checkOutput("latency0", 32'(cyc), 32'(e0.cyc + 1));
                checkOutput("stateTrack0", 32'(st0), 2);
            end
            lastMv0 = cyc;
        end
        if (to0 === 1'b1) begin
            toCnt0++;
            checkOutput("toDelay0", 32'(cyc - lastMv0), TMO);
            checkOutput("toPeriod0", period0, 0);
            checkOutput("toLocked0", 32'(lk0), 0);
            checkOutput("toState0", 32'(st0), 0);
        end
    end

    // Same checks for the two-flop synchronised instance, two cycles later
    always @(negedge clk_in) begin
        if (mv1 === 1'b1) begin
            if (q1.size() == 0) checkOutput("mvSpurious1", 1, 0);
            else begin
                e1 = q1.pop_front();
                checkOutput("period1", period1, e1.per);
                checkOutput("high1", high1, e1.hi);
                checkOutput("lockedMv1", 32'(lk1), 32'(e1.lk));
                checkOutput("latency1", 32'(cyc), 32'(e1.cyc + 3));
                checkOutput("stateTrack1", 32'(st1), 2);
            end
            lastMv1 = cyc;
        end
        if (to1 === 1'b1) begin
            toCnt1++;
            checkOutput("toDelay1", 32'(cyc - lastMv1), TMO);
            checkOutput("toPeriod1", period1, 0);
            checkOutput("toLocked1", 32'(lk1), 0);
            checkOutput("toState1", 32'(st1), 0);
        end
    end

    initial begin
        repeat (3) @(negedge clk_in);
        checkAllZero("rst");
        reset = 1'b1;
        setEnable(1'b1);
        repeat (4) driveCycle(1'b0);

        // Lock on divide-by-4: the first rise only arms
        applyStimulus(2, 2, 1);
        checkBoth("armed", 32'(st0), 32'(st1), 1);
        applyStimulus(2, 2, 6);
        checkBoth("lock4", 32'(lk0), 32'(lk1), 1);

        // Ratio change to divide-by-8 and relock
        applyStimulus(4, 4, 6);
        checkBoth("lock8", 32'(lk0), 32'(lk1), 1);
        checkBoth("per8", period0, period1, 8);

        // Odd ratio 3 high / 2 low
        applyStimulus(3, 2, 6);
        checkBoth("perOdd", period0, period1, 5);
        checkBoth("hiOdd", high0, high1, 3);

        // Loss of signal after relocking on divide-by-4
        applyStimulus(2, 2, 6);
        repeat (TMO + 10) driveCycle(1'b0);
        checkBoth("losState", 32'(st0), 32'(st1), 0);
        checkBoth("losPeriod", period0, period1, 0);
        checkBoth("losLocked", 32'(lk0), 32'(lk1), 0);
        checkBoth("losCount", 32'(toCnt0), 32'(toCnt1), 1);

        // One-cycle reset while locked, released with sig_in high
        applyStimulus(2, 2, 6);
        checkBoth("preRstLock", 32'(lk0), 32'(lk1), 1);
        reset = 1'b0;
        mdlActive = 1'b0;
        driveCycle(1'b1);
        checkAllZero("midRst");
        reset = 1'b1;
        driveCycle(1'b1);
        repeat (2) driveCycle(1'b0);
        applyStimulus(2, 2, 6);
        checkBoth("relockRst", 32'(lk0), 32'(lk1), 1);

        // Enable gating for 20 cycles while locked
        setEnable(1'b0);
        applyStimulus(2, 2, 5);
        checkBoth("disState", 32'(st0), 32'(st1), 0);
        checkBoth("disLocked", 32'(lk0), 32'(lk1), 0);
        checkBoth("disPeriod", period0, period1, 4);
        setEnable(1'b1);
        applyStimulus(2, 2, 6);
        checkBoth("relockEn", 32'(lk0), 32'(lk1), 1);
        repeat (4) driveCycle(1'b0);

        checkBoth("qEmpty", 32'(q0.size()), 32'(q1.size()), 0);
        checkBoth("toTotal", 32'(toCnt0), 32'(toCnt1), 32'(expTo));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
